// File: rtl/cdc_pkg.sv
// Shared definitions for the req/ack multi-bit clock-domain crossing.
// Used by both the receive and the matching transmit block.
`timescale 1ns/1ps
package cdc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VALID = 2'd1,
        ST_ACK   = 2'd2
    } cdc_state_e;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    // Out-of-range depths are pulled into the legal window.
    function automatic int sync_depth(input int n);
        if (n < SYNC_STAGES_MIN)
            return SYNC_STAGES_MIN;
        if (n > SYNC_STAGES_MAX)
            return SYNC_STAGES_MAX;
        return n;
    endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// N-flop single-bit synchroniser for an asynchronous level.
// Clears asynchronously; q is the last flop of the chain.
`timescale 1ns/1ps
module cdc_sync_bit #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            chain <= '0;
        else
            chain <= {chain[N-2:0], d};
    end

    assign q = chain[N-1];

endmodule

// File: rtl/handshake_cdc_rx.sv
// Receive side of the 4-phase req/ack crossing: captures a word held
// stable by the source, hands it downstream, and returns a flopped ack.
`timescale 1ns/1ps
module handshake_cdc_rx
    import cdc_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic [DATA_W-1:0] data_a,
    output logic              ack_b,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  xfer_cnt,
    output logic              proto_err
);

    localparam int STAGES = sync_depth(SYNC_STAGES);

    cdc_state_e state;
    logic       req_s;

    cdc_sync_bit #(
        .N (STAGES)
    ) u_req_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (req_a),
        .q     (req_s)
    );

    // data_a is only sampled once req_s proves it has settled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            dout       <= '0;
            dout_valid <= 1'b0;
            ack_b      <= 1'b0;
            busy       <= 1'b0;
            xfer_cnt   <= '0;
            proto_err  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req_s) begin
                        dout       <= data_a;
                        dout_valid <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    // Accept wins over a simultaneous req drop.
                    if (dout_ready) begin
                        dout_valid <= 1'b0;
                        ack_b      <= 1'b1;
                        state      <= ST_ACK;
                    end else if (!req_s) begin
                        proto_err  <= 1'b1;
                    end
                end
                ST_ACK: begin
                    if (!req_s) begin
                        ack_b    <= 1'b0;
                        busy     <= 1'b0;
                        xfer_cnt <= xfer_cnt + CNT_W'(1);
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    dout_valid <= 1'b0;
                    ack_b      <= 1'b0;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_handshake_cdc_rx.sv
// Scoreboard bench: a slow source drives req/data, a monitor checks
// every accepted word against the queue of words the source sent.
`timescale 1ns/100ps
module tb_handshake_cdc_rx;

    logic       clk;
    logic       src_clk;
    logic       rst_n;
    logic       req_a;
    logic [7:0] data_a;
    logic       dout_ready;

    logic       ack_b;
    logic [7:0] dout;
    logic       dout_valid;
    logic       busy;
    logic [7:0] xfer_cnt;
    logic       proto_err;

    logic       w_ack_b;
    logic [7:0] w_dout;
    logic       w_dout_valid;
    logic       w_busy;
    logic [1:0] w_xfer_cnt;
    logic       w_proto_err;

    int         checks;
    int         failures;
    int         exp_cnt;
    logic [7:0] exp_q[$];

    logic       rdy_rand;
    logic       rdy_force;

    handshake_cdc_rx #(
        .DATA_W      (8),
        .SYNC_STAGES (2),
        .CNT_W       (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_a      (req_a),
        .data_a     (data_a),
        .ack_b      (ack_b),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .xfer_cnt   (xfer_cnt),
        .proto_err  (proto_err)
    );

    handshake_cdc_rx #(
        .DATA_W      (8),
        .SYNC_STAGES (2),
        .CNT_W       (2)
    ) dut_w (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_a      (req_a),
        .data_a     (data_a),
        .ack_b      (w_ack_b),
        .dout       (w_dout),
        .dout_valid (w_dout_valid),
        .dout_ready (dout_ready),
        .busy       (w_busy),
        .xfer_cnt   (w_xfer_cnt),
        .proto_err  (w_proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        src_clk = 1'b0;
        #3.3;
        forever #50 src_clk = ~src_clk;
    end

    always @(posedge clk) begin
        #1;
        if (rdy_rand)
            dout_ready = 1'($urandom_range(0, 1));
        else
            dout_ready = rdy_force;
    end

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: one pop per dout_valid & dout_ready edge.
    always @(negedge clk) begin
        if (rst_n && dout_valid && dout_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL dup_word: got %0h expected none", dout);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("dout", {24'd0, dout}, {24'd0, e});
                check("w_dout", {24'd0, w_dout}, {24'd0, e});
            end
        end
    end

    task automatic wait_for(input int sel, input logic lvl,
                            input string name);
        bit hit;
        hit = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ((sel == 0 ? ack_b : dout_valid) == lvl) begin
                hit = 1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL %s: got timeout expected %0b", name, lvl);
        end
    endtask

    task automatic check_cnt(input string name);
        check(name, {24'd0, xfer_cnt}, 32'(exp_cnt % 256));
        check({name, "_w"}, {30'd0, w_xfer_cnt}, 32'(exp_cnt % 4));
    endtask

    task automatic send(input logic [7:0] d);
        @(posedge src_clk);
        data_a = d;
        req_a  = 1'b1;
        exp_q.push_back(d);
        wait_for(0, 1'b1, "ack_rise");
        @(posedge src_clk);
        req_a = 1'b0;
        wait_for(0, 1'b0, "ack_fall");
        exp_cnt++;
        @(posedge src_clk);
        data_a = 8'($urandom);
    endtask

    initial begin
        int  n;
        bit  held;

        checks    = 0;
        failures  = 0;
        exp_cnt   = 0;
        rst_n     = 1'b0;
        req_a     = 1'b0;
        data_a    = 8'h00;
        rdy_rand  = 1'b0;
        rdy_force = 1'b1;
        dout_ready = 1'b1;

        #2;
        check("rst_ack", {31'd0, ack_b}, 32'd0);
        check("rst_dout", {24'd0, dout}, 32'd0);
        check("rst_valid", {31'd0, dout_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_perr", {31'd0, proto_err}, 32'd0);
        check_cnt("rst_cnt");
        #20.5 rst_n = 1'b1;

        // 1: single transfer with latency measurement
        @(posedge src_clk);
        data_a = 8'hA5;
        req_a  = 1'b1;
        exp_q.push_back(8'hA5);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (dout_valid)
                break;
        end
        check("latency", 32'(n), 32'd3);
        check("busy_valid", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        check("t1_ack", {31'd0, ack_b}, 32'd1);
        check("t1_valid", {31'd0, dout_valid}, 32'd0);
        @(posedge src_clk);
        req_a = 1'b0;
        wait_for(0, 1'b0, "t1_ack_fall");
        exp_cnt++;
        check_cnt("t1_cnt");

        // 2: backpressure
        rdy_force = 1'b0;
        @(posedge src_clk);
        data_a = 8'h3C;
        req_a  = 1'b1;
        exp_q.push_back(8'h3C);
        wait_for(1, 1'b1, "t2_valid");
        held = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!dout_valid || ack_b || dout_ready)
                held = 0;
        end
        check("t2_held", {31'd0, held}, 32'd1);
        rdy_force = 1'b1;
        @(negedge clk);
        while (!dout_ready) @(negedge clk);
        @(posedge clk);
        #1;
        check("t2_ack", {31'd0, ack_b}, 32'd1);
        @(posedge src_clk);
        req_a = 1'b0;
        wait_for(0, 1'b0, "t2_ack_fall");
        exp_cnt++;
        check_cnt("t2_cnt");

        // 3: back-to-back
        for (int i = 1; i <= 4; i++)
            send(8'(i));
        check_cnt("t3_cnt");
        check("t3_drain", 32'(exp_q.size()), 32'd0);

        // random data with random backpressure
        rdy_rand = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(8'($urandom));
            check_cnt("rand_cnt");
        end
        rdy_rand = 1'b0;
        check("no_perr", {31'd0, proto_err}, 32'd0);

        // 4: protocol error
        rdy_force = 1'b0;
        repeat (2) @(posedge clk);
        @(posedge src_clk);
        data_a = 8'($urandom);
        req_a  = 1'b1;
        exp_q.push_back(data_a);
        wait_for(1, 1'b1, "t4_valid");
        @(posedge src_clk);
        req_a = 1'b0;
        repeat (5) @(negedge clk);
        check("t4_perr", {31'd0, proto_err}, 32'd1);
        check("t4_valid_held", {31'd0, dout_valid}, 32'd1);
        rdy_force = 1'b1;
        wait_for(0, 1'b1, "t4_ack_rise");
        wait_for(0, 1'b0, "t4_ack_fall");
        exp_cnt++;
        check_cnt("t4_cnt");
        send(8'h5A);
        check("t4_sticky", {31'd0, proto_err}, 32'd1);

        // 5: reset while in ACK with req still high
        @(posedge src_clk);
        data_a = 8'($urandom);
        req_a  = 1'b1;
        exp_q.push_back(data_a);
        wait_for(0, 1'b1, "t5_ack");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_ack", {31'd0, ack_b}, 32'd0);
        check("t5_valid", {31'd0, dout_valid}, 32'd0);
        check("t5_perr", {31'd0, proto_err}, 32'd0);
        exp_cnt = 0;
        check_cnt("t5_cnt");
        exp_q.push_back(data_a);
        #23.4 rst_n = 1'b1;
        wait_for(0, 1'b1, "t5_reack");
        @(posedge src_clk);
        req_a = 1'b0;
        wait_for(0, 1'b0, "t5_ack_fall");
        exp_cnt++;
        check_cnt("t5_cnt_after");
        check("t5_drain", 32'(exp_q.size()), 32'd0);

        // 6: counter wrap on the narrow instance
        rdy_rand = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(8'($urandom));
            check_cnt("t6_cnt");
        end
        rdy_rand = 1'b0;
        repeat (4) @(posedge clk);
        check("final_drain", 32'(exp_q.size()), 32'd0);
        check("final_busy", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
